l2_way_array: RTL

L2_WAY_ARRAY -- requirements
Module: l2_way_array

---
 rtl/l2_pkg.sv | 7 +
 rtl/l2_bank.sv | 32 +++
 rtl/l2_way_array.sv | 74 +++++++
 3 files changed

// File: rtl/l2_pkg.sv
// l2_pkg: shared FSM state type and default parameters for the L2 way array
package l2_pkg;
  typedef enum logic {SWEEP, IDLE} state_t;
  localparam int def_s_index = 3;
  localparam int def_width = 256;
  localparam int def_num_ways = 2;
endpackage

// File: rtl/l2_bank.sv
// l2_bank: one way of byte-masked storage with a registered write-first read port
module l2_bank
  import l2_pkg::*;
#(
  parameter int s_index = def_s_index,
  parameter int width = def_width
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 re,
  input  logic                 we,
  input  logic [s_index-1:0]   index,
  input  logic [width/8-1:0]   wmask,
  input  logic [width-1:0]     datain,
  output logic [width-1:0]     dataout
);
  logic [width-1:0] mem [2**s_index];
  logic [width-1:0] merged;
  // byte-merge the incoming data over the stored entry
  always_comb begin
    merged = mem[index];
    for (int b = 0; b < width / 8; b++)
      if (wmask[b]) merged[8*b +: 8] = datain[8*b +: 8];
  end
  // storage is deliberately left unreset; validity lives in the valid bits
  always_ff @(posedge clk)
    if (we) mem[index] <= merged;
  // read port returns the merged value when a write hits the same entry
  always_ff @(posedge clk or posedge rst)
    if (rst) dataout <= '0;
    else if (re) dataout <= we ? merged : mem[index];
endmodule

// File: rtl/l2_way_array.sv
// l2_way_array: multi-way L2 data array with per-set valid bits and a sweeping flush
module l2_way_array
  import l2_pkg::*;
#(
  parameter int s_index = def_s_index,
  parameter int width = def_width,
  parameter int num_ways = def_num_ways,
  localparam int lw = num_ways > 1 ? $clog2(num_ways) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  output logic                      ready,
  input  logic                      read,
  input  logic                      load,
  input  logic [lw-1:0]             load_way,
  input  logic [s_index-1:0]        index,
  input  logic [width/8-1:0]        wmask,
  input  logic [width-1:0]          datain,
  output logic [num_ways*width-1:0] dataout,
  output logic [num_ways-1:0]       valid_out
);
  state_t state, state_n;
  logic [s_index-1:0] cnt, cnt_n;
  logic [num_ways-1:0] hit;
  logic [num_ways-1:0][2**s_index-1:0] vld;
  logic rd;
  assign ready = state == IDLE;
  assign rd = ready & read;
  // a load is live only when idle, not beaten by flush, and aimed at an existing way
  always_comb
    for (int w = 0; w < num_ways; w++)
      hit[w] = ready & load & ~flush & (int'(load_way) == w);
  // state register; reset restarts the sweep from set 0
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= SWEEP;
      cnt <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
    end
  // sweep visits every set once then idles; flush while idle starts a new sweep
  always_comb begin
    state_n = state == SWEEP ? (&cnt ? IDLE : SWEEP) : (flush ? SWEEP : IDLE);
    cnt_n = state == SWEEP ? cnt + 1'b1 : '0;
  end
  // valid bits are cleared by the sweep and set by a live load
  always_ff @(posedge clk)
    for (int w = 0; w < num_ways; w++)
      if (state == SWEEP) vld[w][cnt] <= 1'b0;
      else if (hit[w]) vld[w][index] <= 1'b1;
  // registered per-way valid for the read set, write-first like the data
  always_ff @(posedge clk or posedge rst)
    if (rst) valid_out <= '0;
    else if (rd)
      for (int w = 0; w < num_ways; w++)
        valid_out[w] <= hit[w] | vld[w][index];
  for (genvar g = 0; g < num_ways; g++) begin : g_way
    l2_bank #(
      .s_index(s_index),
      .width(width)
    ) u_bank (
      .clk(clk),
      .rst(rst),
      .re(rd),
      .we(hit[g]),
      .index(index),
      .wmask(wmask),
      .datain(datain),
      .dataout(dataout[g*width +: width])
    );
  end
endmodule
